// File: rtl/q_mean_acc.sv
// q_mean_acc: frame sum/count accumulator feeding a combinational Q-format divider (optional flags: Q_MEAN_FLAGS_EN).
// Latency: operands registered on the closing beat's edge, valid the following cycle.
// Backpressure: in_ready drops while operands wait; they are held until out_valid&&out_ready.

`ifndef FIXED_WIDTH
`define FIXED_WIDTH 16
`endif
`ifndef FRAC_BITS
`define FRAC_BITS 8
`endif
`ifndef FIXED_MAX
`define FIXED_MAX {1'b0, {(`FIXED_WIDTH-1){1'b1}}}
`endif
`ifndef FIXED_MIN
`define FIXED_MIN {1'b1, {(`FIXED_WIDTH-1){1'b0}}}
`endif

module q_mean_acc #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [`FIXED_WIDTH-1:0] in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [`FIXED_WIDTH-1:0] out_num,
    output logic [`FIXED_WIDTH-1:0] out_den,
    output logic [CNT_WIDTH-1:0]    out_count
`ifdef Q_MEAN_FLAGS_EN
    ,
    output logic                    out_sat,
    output logic                    out_ovf
`endif
);

    localparam int FW = `FIXED_WIDTH;
    localparam int SW = `FIXED_WIDTH + CNT_WIDTH;

    localparam logic [0:0] ST_ACC = 1'b0;
    localparam logic [0:0] ST_OUT = 1'b1;

    localparam logic signed [SW-1:0] SUM_MAX = {{CNT_WIDTH{1'b0}}, `FIXED_MAX};
    localparam logic signed [SW-1:0] SUM_MIN = {{CNT_WIDTH{1'b1}}, `FIXED_MIN};
    localparam logic [SW-1:0]        DEN_MAX = {{CNT_WIDTH{1'b0}}, `FIXED_MAX};
    localparam logic [CNT_WIDTH-1:0] CNT_LIM = {CNT_WIDTH{1'b1}};

    logic [0:0]             state;
    logic signed [SW-1:0]   sum;
    logic [CNT_WIDTH-1:0]   count;

    logic                   accept;
    logic                   close;
    logic signed [SW-1:0]   sum_nxt;
    logic [CNT_WIDTH-1:0]   cnt_nxt;
    logic [SW-1:0]          den_full;
    logic                   num_hi;
    logic                   num_lo;
    logic                   den_hi;
    logic [FW-1:0]          num_sat;
    logic [FW-1:0]          den_sat;

    assign in_ready = (state == ST_ACC);
    assign accept   = in_valid && in_ready;
    assign sum_nxt  = sum + $signed({{CNT_WIDTH{in_data[FW-1]}}, in_data});
    assign cnt_nxt  = count + 1'b1;
    assign close    = accept && (in_last || (cnt_nxt == CNT_LIM));

    // The count shift is done at sum width so the clamp sees the true value.
    assign den_full = {{FW{1'b0}}, cnt_nxt} << `FRAC_BITS;
    assign num_hi   = (sum_nxt > SUM_MAX);
    assign num_lo   = (sum_nxt < SUM_MIN);
    assign den_hi   = (den_full > DEN_MAX);

    always_comb begin
        num_sat = sum_nxt[FW-1:0];
        if (num_hi) begin
            num_sat = `FIXED_MAX;
        end else if (num_lo) begin
            num_sat = `FIXED_MIN;
        end
        den_sat = den_hi ? `FIXED_MAX : den_full[FW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_ACC;
            sum       <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_num   <= '0;
            out_den   <= '0;
            out_count <= '0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (close) begin
                        state     <= ST_OUT;
                        sum       <= '0;
                        count     <= '0;
                        out_valid <= 1'b1;
                        out_num   <= num_sat;
                        out_den   <= den_sat;
                        out_count <= cnt_nxt;
                    end else if (accept) begin
                        sum   <= sum_nxt;
                        count <= cnt_nxt;
                    end
                end
                default: begin
                    if (out_ready) begin
                        state     <= ST_ACC;
                        out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef Q_MEAN_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sat <= 1'b0;
            out_ovf <= 1'b0;
        end else if (close) begin
            out_sat <= num_hi || num_lo || den_hi;
            out_ovf <= !in_last;
        end
    end
`endif

endmodule

// File: tb/tb_q_mean_acc.sv
// Directed bench for q_mean_acc: one 8-bit-counter instance and one 4-bit-counter instance.
`timescale 1ns/1ps

module tb_q_mean_acc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_num;
    logic [15:0] out_den;
    logic [7:0]  out_count;

    logic        in_valid4 = 1'b0;
    logic        in_ready4;
    logic [15:0] in_data4 = '0;
    logic        in_last4 = 1'b0;
    logic        out_valid4;
    logic        out_ready4 = 1'b0;
    logic [15:0] out_num4;
    logic [15:0] out_den4;
    logic [3:0]  out_count4;

`ifdef Q_MEAN_FLAGS_EN
    logic        out_sat, out_ovf, out_sat4, out_ovf4;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    q_mean_acc #(.CNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_num(out_num), .out_den(out_den), .out_count(out_count)
`ifdef Q_MEAN_FLAGS_EN
        , .out_sat(out_sat), .out_ovf(out_ovf)
`endif
    );

    q_mean_acc #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .in_last(in_last4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .out_num(out_num4), .out_den(out_den4), .out_count(out_count4)
`ifdef Q_MEAN_FLAGS_EN
        , .out_sat(out_sat4), .out_ovf(out_ovf4)
`endif
    );

    // One beat presented for exactly one edge; outputs are sampled 1ns after that edge.
    task automatic send_beat(input logic [15:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_num, out_den, out_count} !== 41'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%0b num=%h den=%h cnt=%0d, want all 0",
                     out_valid, out_num, out_den, out_count);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %0b, want 1", in_ready);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        send_beat(16'h0180, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_valid: got %0b, want 0", out_valid);
        end
        send_beat(16'h0280, 1'b1);
        checks++;
        if ({out_valid, in_ready, out_num, out_den, out_count} !== {1'b1, 1'b0, 16'h0400, 16'h0200, 8'd2}) begin
            errors++;
            $display("FAIL basic_frame: got v=%0b rdy=%0b num=%h den=%h cnt=%0d, want v=1 rdy=0 num=0400 den=0200 cnt=2",
                     out_valid, in_ready, out_num, out_den, out_count);
        end
`ifdef Q_MEAN_FLAGS_EN
        checks++;
        if ({out_sat, out_ovf} !== 2'b00) begin
            errors++;
            $display("FAIL basic_flags: got sat=%0b ovf=%0b, want 0 0", out_sat, out_ovf);
        end
`endif
        handshake();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) send_beat(16'h7F00, i == 3);
        checks++;
        if ({out_valid, out_num, out_den, out_count} !== {1'b1, 16'h7FFF, 16'h0400, 8'd4}) begin
            errors++;
            $display("FAIL sat_pos: got v=%0b num=%h den=%h cnt=%0d, want v=1 num=7fff den=0400 cnt=4",
                     out_valid, out_num, out_den, out_count);
        end
`ifdef Q_MEAN_FLAGS_EN
        checks++;
        if (out_sat !== 1'b1) begin
            errors++;
            $display("FAIL sat_pos_flag: got %0b, want 1", out_sat);
        end
`endif
        handshake();
        for (int i = 0; i < 2; i++) send_beat(16'h8000, i == 1);
        checks++;
        if ({out_valid, out_num, out_den, out_count} !== {1'b1, 16'h8000, 16'h0200, 8'd2}) begin
            errors++;
            $display("FAIL sat_neg: got v=%0b num=%h den=%h cnt=%0d, want v=1 num=8000 den=0200 cnt=2",
                     out_valid, out_num, out_den, out_count);
        end
`ifdef Q_MEAN_FLAGS_EN
        checks++;
        if (out_sat !== 1'b1) begin
            errors++;
            $display("FAIL sat_neg_flag: got %0b, want 1", out_sat);
        end
`endif
        handshake();
    endtask

    task automatic test_counter_limit();
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 15; i++) begin
                in_valid4 = 1'b1;
                in_data4  = 16'h0100;
                in_last4  = (pass == 1) && (i == 14);
                @(posedge clk);
                #1;
                in_valid4 = 1'b0;
                in_last4  = 1'b0;
                if (i == 13) begin
                    checks++;
                    if (out_valid4 !== 1'b0) begin
                        errors++;
                        $display("FAIL limit_early_valid: got %0b after beat 14, want 0", out_valid4);
                    end
                end
            end
            checks++;
            if ({out_valid4, out_num4, out_den4, out_count4} !== {1'b1, 16'h0F00, 16'h0F00, 4'd15}) begin
                errors++;
                $display("FAIL limit_frame%0d: got v=%0b num=%h den=%h cnt=%0d, want v=1 num=0f00 den=0f00 cnt=15",
                         pass, out_valid4, out_num4, out_den4, out_count4);
            end
`ifdef Q_MEAN_FLAGS_EN
            checks++;
            if ({out_sat4, out_ovf4} !== {1'b0, (pass == 0)}) begin
                errors++;
                $display("FAIL limit_flags%0d: got sat=%0b ovf=%0b, want sat=0 ovf=%0b",
                         pass, out_sat4, out_ovf4, pass == 0);
            end
`endif
            out_ready4 = 1'b1;
            @(posedge clk);
            #1;
            out_ready4 = 1'b0;
        end
    endtask

    task automatic test_den_clamp();
        for (int i = 0; i < 200; i++) send_beat(16'h0001, i == 199);
        checks++;
        if ({out_valid, out_num, out_den, out_count} !== {1'b1, 16'h00C8, 16'h7FFF, 8'd200}) begin
            errors++;
            $display("FAIL den_clamp: got v=%0b num=%h den=%h cnt=%0d, want v=1 num=00c8 den=7fff cnt=200",
                     out_valid, out_num, out_den, out_count);
        end
`ifdef Q_MEAN_FLAGS_EN
        checks++;
        if ({out_sat, out_ovf} !== 2'b10) begin
            errors++;
            $display("FAIL den_clamp_flags: got sat=%0b ovf=%0b, want 1 0", out_sat, out_ovf);
        end
`endif
        handshake();
    endtask

    task automatic test_back_pressure();
        send_beat(16'h0100, 1'b1);
        in_valid = 1'b1;
        in_data  = 16'h1234;
        in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, in_ready, out_num, out_den, out_count} !== {1'b1, 1'b0, 16'h0100, 16'h0100, 8'd1}) begin
                errors++;
                $display("FAIL hold_cycle%0d: got v=%0b rdy=%0b num=%h den=%h cnt=%0d, want v=1 rdy=0 num=0100 den=0100 cnt=1",
                         i, out_valid, in_ready, out_num, out_den, out_count);
            end
        end
        handshake();
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL hold_release: got v=%0b rdy=%0b, want v=0 rdy=1", out_valid, in_ready);
        end
        send_beat(16'h0200, 1'b1);
        checks++;
        if ({out_valid, out_num, out_count} !== {1'b1, 16'h0200, 8'd1}) begin
            errors++;
            $display("FAIL hold_no_leak: got v=%0b num=%h cnt=%0d, want v=1 num=0200 cnt=1",
                     out_valid, out_num, out_count);
        end
        handshake();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) send_beat(16'h0300, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, out_num, out_count} !== {1'b0, 1'b1, 16'h0000, 8'd0}) begin
            errors++;
            $display("FAIL reset_midframe: got v=%0b rdy=%0b num=%h cnt=%0d, want v=0 rdy=1 num=0 cnt=0",
                     out_valid, in_ready, out_num, out_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_beat(16'h0100, 1'b1);
        checks++;
        if ({out_valid, out_num, out_den, out_count} !== {1'b1, 16'h0100, 16'h0100, 8'd1}) begin
            errors++;
            $display("FAIL reset_next_frame: got v=%0b num=%h den=%h cnt=%0d, want v=1 num=0100 den=0100 cnt=1",
                     out_valid, out_num, out_den, out_count);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, out_num, out_den, out_count} !== {1'b0, 1'b1, 16'h0000, 16'h0000, 8'd0}) begin
            errors++;
            $display("FAIL reset_in_out: got v=%0b rdy=%0b num=%h den=%h cnt=%0d, want v=0 rdy=1 all 0",
                     out_valid, in_ready, out_num, out_den, out_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_beat(16'h0100, 1'b1);
        checks++;
        if ({out_valid, out_num, out_count} !== {1'b1, 16'h0100, 8'd1}) begin
            errors++;
            $display("FAIL reset_after_out: got v=%0b num=%h cnt=%0d, want v=1 num=0100 cnt=1",
                     out_valid, out_num, out_count);
        end
        handshake();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_counter_limit();
        test_den_clamp();
        test_back_pressure();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/q_mean_acc.md
# q_mean_acc

Streaming fixed-point accumulator that sits directly upstream of the combinational fixed-point divider. It collects a frame of signed Q-format samples over a valid/ready input stream. On the last beat it presents the saturated frame sum as the numerator and the sample count, converted to Q format, as the denominator, both registered behind a valid/ready output handshake. The downstream divider produces the frame mean from these two operands.

## Interface

Parameters:
- CNT_WIDTH, 8 — sample counter width; max frame length is 2^CNT_WIDTH-1.

Fixed-point format comes from the shared include: `FIXED_WIDTH, `FRAC_BITS, `FIXED_MAX, `FIXED_MIN.

Ports:
- clk  in  1 — single clock, rising edge.
- rst_n  in  1 — asynchronous, active-low reset.
- in_valid  in  1 — input sample valid.
- in_ready  out  1 — block can accept a sample.
- in_data  in  `FIXED_WIDTH — signed Q sample.
- in_last  in  1 — final sample of the frame.
- out_valid  out  1 — operands valid.
- out_ready  in  1 — downstream accepts operands.
- out_num  out  `FIXED_WIDTH — signed saturated frame sum (divider operand a).
- out_den  out  `FIXED_WIDTH — count << `FRAC_BITS, saturated (divider operand b).
- out_count  out  CNT_WIDTH — raw sample count of the frame.
- out_sat  out  1 — out_num or out_den was clamped. Present only with Q_MEAN_FLAGS_EN.
- out_ovf  out  1 — frame closed by counter limit, not by in_last. Present only with Q_MEAN_FLAGS_EN.

## Operation

- Two states: ACC (in_ready=1, out_valid=0) and OUT (in_ready=0, out_valid=1). Reset state is ACC.
- Internal sum is signed, `FIXED_WIDTH+CNT_WIDTH bits wide and cannot overflow. Saturation is applied only when the output is formed.
- ACC: each beat with in_valid&&in_ready adds sign-extended in_data to the sum and increments count.
- Frame close: an accepted beat with in_last=1, or an accepted beat that brings count to 2^CNT_WIDTH-1.
  - Frame close registers all outputs and moves the block to OUT.
  - The sum and count are then cleared to 0.
  - ovf is set when the counter limit closed the frame and in_last=0. It is clear when in_last=1, including the case where in_last coincides with the counter limit.
- out_num: sum > `FIXED_MAX gives `FIXED_MAX; sum < `FIXED_MIN gives `FIXED_MIN; otherwise the low `FIXED_WIDTH bits.
- out_den: count << `FRAC_BITS, computed at full width. If the result exceeds `FIXED_MAX, it is clamped to `FIXED_MAX.
- out_sat = clamp on out_num OR clamp on out_den.
- OUT: all outputs are held stable until out_valid&&out_ready. On that edge the block returns to ACC, and out_valid drops on the same edge.
- out_den is never 0 while out_valid=1, because a frame always contains at least 1 sample. The divider's divide-by-zero path is therefore never exercised by this block.
- Input beats presented while in OUT are not accepted (in_ready=0). The upstream source must hold them.
- Reset (asynchronous, any time, including mid-frame or in OUT):
  - State returns to ACC; sum and count are cleared.
  - out_valid=0, out_num=0, out_den=0, out_count=0, out_sat=0, out_ovf=0.
  - in_ready=1 from the first edge after rst_n is released.

## Timing

- in_ready = (state==ACC). It is a registered-state decode with no combinational path from out_ready.
- Latency: a closing beat accepted at edge k gives out_valid=1 after edge k, so operands are visible in cycle k+1.
- Handshake at edge j (out_valid&&out_ready) gives in_ready=1 in cycle j+1. The block has no same-cycle bypass.
- Throughput: one sample per cycle within a frame. Each frame costs at least 1 extra cycle in OUT.
- The downstream divider is combinational. A mean is valid whenever out_valid=1.

## Configuration

- Q_MEAN_FLAGS_EN defined: ports out_sat and out_ovf exist and are registered with the other outputs as described above.
- Not defined: both ports and their logic are omitted. Saturation, counter-limit frame close, and all other behaviour are identical.

## Test plan

Bench configuration: `FIXED_WIDTH=16, `FRAC_BITS=8, CNT_WIDTH=8 unless stated otherwise.

- Samples 0x0180, 0x0280 (last on 2nd) -> out_num=0x0400, out_den=0x0200, out_count=2, sat=0, ovf=0; out_valid rises the cycle after the last beat.
- Four samples of 0x7F00, then two samples of 0x8000 as a second frame -> frame 1: out_num=0x7FFF, sat=1; frame 2: out_num=0x8000, sat=1, out_den=0x0200.
- CNT_WIDTH=4, 15 beats of 0x0100 with in_last=0 -> frame closes on beat 15; out_num=0x0F00, out_den=0x0F00, out_count=15, ovf=1.
- 200 beats of 0x0001 -> out_den clamps (200<<8 > 0x7FFF) to 0x7FFF, out_num=0x00C8, sat=1.
- After a frame, hold out_ready=0 for 3 cycles while in_valid=1 -> outputs stable, in_ready=0, no beats accepted; on the handshake, out_valid drops and in_ready=1 the next cycle.
- Assert rst_n=0 after 3 beats of a frame and while in OUT -> all outputs 0, in_ready=1; a following 1-beat frame of 0x0100 gives out_num=0x0100, out_count=1.
